// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter_pkg
// Brief    : Shared constants for the common-data-bus arbiter: ROB tag width,
//            CDB source encodings and CDB payload field widths.
// Revision : 1.0  initial release
// ============================================================================
package cdb_arbiter_pkg;

    // ROB tag width shared with the ROB / reservation station
    localparam int ROB_WIDTH_BIT = 3;

    // CDB payload field widths
    localparam int CDB_VALUE_W  = 32;
    localparam int CDB_TAKEN_W  = 1;
    localparam int CDB_TARGET_W = 32;

    // Grant source encoding as seen on cdb_src
    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;

    // Total packed width of one buffered result {rob_id, value, taken, target}
    function automatic int cdb_payload_w(input int rob_w);
        return rob_w + CDB_VALUE_W + CDB_TAKEN_W + CDB_TARGET_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cdb_fifo
// Brief    : Small synchronous FIFO buffering completed results of one
//            execution unit. Clear empties it in one cycle; pointers wrap
//            naturally, the count is one bit wider than the pointers.
// Revision : 1.0  initial release
// ============================================================================
module cdb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                   c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0]   c_ptr_one = 1;
    localparam logic [c_ptr_w:0]     c_cnt_one = 1;
    localparam logic [c_ptr_w:0]     c_depth   = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w:0]   count_q,  count_d;

    // Next-state pointers and count; clear wins over push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                wr_ptr_d = wr_ptr_q + c_ptr_one;
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_one;
            end
            case ({i_push, i_pop})
                2'b10:   count_d = count_q + c_cnt_one;
                2'b01:   count_d = count_q - c_cnt_one;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the count gates reads
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_full  = (count_q == c_depth);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Common-data-bus arbiter. Buffers ALU and LSB results in one
//            FIFO each and grants one of them per cycle onto the registered
//            CDB. ROB flush discards everything in flight; rdy_in low pauses.
// Config   : CDB_ROUND_ROBIN_EN defined   -> round-robin on contention
//            CDB_ROUND_ROBIN_EN undefined -> fixed priority, LSB wins ties
// Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_WIDTH_BIT = cdb_arbiter_pkg::ROB_WIDTH_BIT,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [ROB_WIDTH_BIT-1:0]  alu_rob_id,
    input  logic [CDB_VALUE_W-1:0]    alu_value,
    input  logic                      alu_br_taken,
    input  logic [CDB_TARGET_W-1:0]   alu_br_target,
    input  logic                      lsb_valid,
    output logic                      lsb_ready,
    input  logic [ROB_WIDTH_BIT-1:0]  lsb_rob_id,
    input  logic [CDB_VALUE_W-1:0]    lsb_value,
    output logic                      cdb_valid,
    output logic [ROB_WIDTH_BIT-1:0]  cdb_rob_id,
    output logic [CDB_VALUE_W-1:0]    cdb_value,
    output logic                      cdb_br_taken,
    output logic [CDB_TARGET_W-1:0]   cdb_br_target,
    output logic                      cdb_src
);

    localparam int                 c_payload_w = cdb_payload_w(ROB_WIDTH_BIT);
    localparam int                 c_cnt_w     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);
    // Payload bit positions, packed as {rob_id, value, taken, target}
    localparam int                 c_tg_lsb    = 0;
    localparam int                 c_tk_bit    = CDB_TARGET_W;
    localparam int                 c_val_lsb   = CDB_TARGET_W + CDB_TAKEN_W;
    localparam int                 c_rob_lsb   = c_val_lsb + CDB_VALUE_W;

    logic                     w_alu_push, w_lsb_push;
    logic                     w_alu_pop,  w_lsb_pop;
    logic                     w_clear;
    logic [c_payload_w-1:0]   w_alu_din,  w_lsb_din;
    logic [c_payload_w-1:0]   w_alu_head, w_lsb_head, w_head;
    logic                     w_alu_full, w_lsb_full;
    logic                     w_alu_empty, w_lsb_empty;
    logic [c_cnt_w-1:0]       w_alu_count, w_lsb_count;
    logic                     w_grant_valid;
    cdb_src_e                 w_grant_src;

    cdb_src_e                 last_grant_q, last_grant_d;
    logic                     cdb_valid_q,     cdb_valid_d;
    logic [ROB_WIDTH_BIT-1:0] cdb_rob_id_q,    cdb_rob_id_d;
    logic [CDB_VALUE_W-1:0]   cdb_value_q,     cdb_value_d;
    logic                     cdb_br_taken_q,  cdb_br_taken_d;
    logic [CDB_TARGET_W-1:0]  cdb_br_target_q, cdb_br_target_d;
    logic                     cdb_src_q,       cdb_src_d;

    // Ready looks at the current count only: no same-cycle pop bypass
    assign alu_ready  = !rst_in && (w_alu_count < c_depth);
    assign lsb_ready  = !rst_in && (w_lsb_count < c_depth);

    assign w_alu_push = alu_valid && alu_ready && rdy_in && !flush;
    assign w_lsb_push = lsb_valid && lsb_ready && rdy_in && !flush;
    assign w_clear    = rdy_in && flush;

    assign w_alu_din  = {alu_rob_id, alu_value, alu_br_taken, alu_br_target};
    // Loads/stores never carry a branch outcome
    assign w_lsb_din  = {lsb_rob_id, lsb_value, {CDB_TAKEN_W{1'b0}}, {CDB_TARGET_W{1'b0}}};

    cdb_fifo #(
        .WIDTH (c_payload_w),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk     (clk_in),
        .rst     (rst_in),
        .i_clear (w_clear),
        .i_push  (w_alu_push),
        .i_pop   (w_alu_pop),
        .i_data  (w_alu_din),
        .o_data  (w_alu_head),
        .o_full  (w_alu_full),
        .o_empty (w_alu_empty),
        .o_count (w_alu_count)
    );

    cdb_fifo #(
        .WIDTH (c_payload_w),
        .DEPTH (FIFO_DEPTH)
    ) u_lsb_fifo (
        .clk     (clk_in),
        .rst     (rst_in),
        .i_clear (w_clear),
        .i_push  (w_lsb_push),
        .i_pop   (w_lsb_pop),
        .i_data  (w_lsb_din),
        .o_data  (w_lsb_head),
        .o_full  (w_lsb_full),
        .o_empty (w_lsb_empty),
        .o_count (w_lsb_count)
    );

    // Grant decision from pre-cycle FIFO contents; nothing granted on pause or flush
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_src   = CDB_SRC_ALU;
        if (rdy_in && !flush) begin
            if (!w_alu_empty && !w_lsb_empty) begin
                w_grant_valid = 1'b1;
`ifdef CDB_ROUND_ROBIN_EN
                if (last_grant_q == CDB_SRC_LSB) begin
                    w_grant_src = CDB_SRC_ALU;
                end else begin
                    w_grant_src = CDB_SRC_LSB;
                end
`else
                w_grant_src = CDB_SRC_LSB;
`endif
            end else if (!w_alu_empty) begin
                w_grant_valid = 1'b1;
                w_grant_src   = CDB_SRC_ALU;
            end else if (!w_lsb_empty) begin
                w_grant_valid = 1'b1;
                w_grant_src   = CDB_SRC_LSB;
            end
        end
    end

    assign w_alu_pop = w_grant_valid && (w_grant_src == CDB_SRC_ALU);
    assign w_lsb_pop = w_grant_valid && (w_grant_src == CDB_SRC_LSB);
    assign w_head    = (w_grant_src == CDB_SRC_LSB) ? w_lsb_head : w_alu_head;

    // Next CDB contents: load granted head, else drop valid and hold data; pause holds all
    always_comb begin
        last_grant_d    = last_grant_q;
        cdb_valid_d     = cdb_valid_q;
        cdb_rob_id_d    = cdb_rob_id_q;
        cdb_value_d     = cdb_value_q;
        cdb_br_taken_d  = cdb_br_taken_q;
        cdb_br_target_d = cdb_br_target_q;
        cdb_src_d       = cdb_src_q;
        if (rdy_in) begin
            if (w_grant_valid) begin
                cdb_valid_d     = 1'b1;
                cdb_rob_id_d    = w_head[c_rob_lsb +: ROB_WIDTH_BIT];
                cdb_value_d     = w_head[c_val_lsb +: CDB_VALUE_W];
                cdb_br_taken_d  = w_head[c_tk_bit];
                cdb_br_target_d = w_head[c_tg_lsb +: CDB_TARGET_W];
                cdb_src_d       = w_grant_src;
                last_grant_d    = w_grant_src;
            end else begin
                cdb_valid_d     = 1'b0;
            end
        end
    end

    // CDB output register and last-grant history
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_grant_q    <= CDB_SRC_LSB;
            cdb_valid_q     <= 1'b0;
            cdb_rob_id_q    <= '0;
            cdb_value_q     <= '0;
            cdb_br_taken_q  <= 1'b0;
            cdb_br_target_q <= '0;
            cdb_src_q       <= 1'b0;
        end else begin
            last_grant_q    <= last_grant_d;
            cdb_valid_q     <= cdb_valid_d;
            cdb_rob_id_q    <= cdb_rob_id_d;
            cdb_value_q     <= cdb_value_d;
            cdb_br_taken_q  <= cdb_br_taken_d;
            cdb_br_target_q <= cdb_br_target_d;
            cdb_src_q       <= cdb_src_d;
        end
    end

    assign cdb_valid     = cdb_valid_q;
    assign cdb_rob_id    = cdb_rob_id_q;
    assign cdb_value     = cdb_value_q;
    assign cdb_br_taken  = cdb_br_taken_q;
    assign cdb_br_target = cdb_br_target_q;
    assign cdb_src       = cdb_src_q;

`ifndef SYNTHESIS
    // Invariants: no push into a full FIFO, and a live broadcast always matches the grant history
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            assert (!(w_alu_push && w_alu_full));
            assert (!(w_lsb_push && w_lsb_full));
            assert (!cdb_valid_q || (cdb_src_q == last_grant_q));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Self-checking bench for cdb_arbiter: directed vector table for
//            single-source traffic, branch fields and pause, plus sequences
//            for contention (both grant policies), flush and mid-stream reset.
// Config   : CDB_ROUND_ROBIN_EN selects which contention pattern is expected
// Revision : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        alu_valid;
    logic        alu_ready;
    logic [2:0]  alu_rob_id;
    logic [31:0] alu_value;
    logic        alu_br_taken;
    logic [31:0] alu_br_target;
    logic        lsb_valid;
    logic        lsb_ready;
    logic [2:0]  lsb_rob_id;
    logic [31:0] lsb_value;
    logic        cdb_valid;
    logic [2:0]  cdb_rob_id;
    logic [31:0] cdb_value;
    logic        cdb_br_taken;
    logic [31:0] cdb_br_target;
    logic        cdb_src;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        av;  logic [2:0] aid; logic [31:0] aval; logic atk; logic [31:0] atg;
        logic        lv;  logic [2:0] lid; logic [31:0] lval;
        logic        rdy;
        logic        ev;  logic [2:0] eid; logic [31:0] e_val; logic etk; logic [31:0] etg;
        logic        esrc; logic ear; logic elr;
    } vec_t;

    vec_t vecs[14];

    cdb_arbiter dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush         (flush),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rob_id    (alu_rob_id),
        .alu_value     (alu_value),
        .alu_br_taken  (alu_br_taken),
        .alu_br_target (alu_br_target),
        .lsb_valid     (lsb_valid),
        .lsb_ready     (lsb_ready),
        .lsb_rob_id    (lsb_rob_id),
        .lsb_value     (lsb_value),
        .cdb_valid     (cdb_valid),
        .cdb_rob_id    (cdb_rob_id),
        .cdb_value     (cdb_value),
        .cdb_br_taken  (cdb_br_taken),
        .cdb_br_target (cdb_br_target),
        .cdb_src       (cdb_src)
    );

    always #5 clk_in = ~clk_in;

    function automatic vec_t mk(
        input logic av, input logic [2:0] aid, input logic [31:0] aval,
        input logic atk, input logic [31:0] atg,
        input logic lv, input logic [2:0] lid, input logic [31:0] lval,
        input logic rdy,
        input logic ev, input logic [2:0] eid, input logic [31:0] e_val,
        input logic etk, input logic [31:0] etg, input logic esrc,
        input logic ear, input logic elr);
        vec_t v;
        v.av = av; v.aid = aid; v.aval = aval; v.atk = atk; v.atg = atg;
        v.lv = lv; v.lid = lid; v.lval = lval; v.rdy = rdy;
        v.ev = ev; v.eid = eid; v.e_val = e_val; v.etk = etk; v.etg = etg;
        v.esrc = esrc; v.ear = ear; v.elr = elr;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; flush = 1'b0;
        alu_valid = 1'b0; alu_rob_id = '0; alu_value = '0; alu_br_taken = 1'b0; alu_br_target = '0;
        lsb_valid = 1'b0; lsb_rob_id = '0; lsb_value = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Contention: both sources offer a new result every cycle for 6 cycles
    task automatic run_contention();
        logic [31:0] qa[$];
        logic [31:0] ql[$];
        logic [31:0] exp_v;
        int          ai = 0;
        int          li = 0;
        logic        acc_a, acc_l;
        logic        exp_src[8];
        logic        exp_ar[9];
        int          exp_ai, exp_li;
`ifdef CDB_ROUND_ROBIN_EN
        exp_src = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_ar  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_ai  = 4; exp_li = 4;
`else
        exp_src = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_ar  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_ai  = 2; exp_li = 6;
`endif
        for (int cyc = 1; cyc <= 10; cyc++) begin
            idle_inputs();
            if (cyc <= 6) begin
                alu_valid = 1'b1; alu_rob_id = ai[2:0]; alu_value = 32'h100 + ai;
                lsb_valid = 1'b1; lsb_rob_id = li[2:0]; lsb_value = 32'h200 + li;
            end
            acc_a = alu_valid && alu_ready;
            acc_l = lsb_valid && lsb_ready;
            step();
            if (acc_a) begin qa.push_back(32'h100 + ai); ai++; end
            if (acc_l) begin ql.push_back(32'h200 + li); li++; end
            if (cyc <= 9) chk($sformatf("contend alu_ready c%0d", cyc), {31'b0, alu_ready}, {31'b0, exp_ar[cyc-1]});
            if (cyc >= 2 && cyc <= 9) begin
                chk($sformatf("contend valid c%0d", cyc), {31'b0, cdb_valid}, 32'd1);
                chk($sformatf("contend src c%0d", cyc), {31'b0, cdb_src}, {31'b0, exp_src[cyc-2]});
                if (cdb_src == 1'b0 && qa.size() > 0) exp_v = qa.pop_front();
                else if (cdb_src == 1'b1 && ql.size() > 0) exp_v = ql.pop_front();
                else exp_v = 32'hFFFF_FFFF;
                chk($sformatf("contend value c%0d", cyc), cdb_value, exp_v);
                chk($sformatf("contend tag c%0d", cyc), {29'b0, cdb_rob_id}, {29'b0, exp_v[2:0]});
            end
            if (cyc == 10) chk("contend drained valid", {31'b0, cdb_valid}, 32'd0);
        end
        chk("contend alu accepted", ai, exp_ai);
        chk("contend lsb accepted", li, exp_li);
        chk("contend leftover", qa.size() + ql.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            alu: v id val tk tg           lsb: v id val   rdy  exp: v id val tk tg src ar lr
        vecs[0]  = mk(1, 3, 32'h11, 0, 0,          0, 0, 0,       1,   0, 0, 0,      0, 0,        0, 1, 1);
        vecs[1]  = mk(0, 0, 0,      0, 0,          0, 0, 0,       1,   1, 3, 32'h11, 0, 0,        0, 1, 1);
        vecs[2]  = mk(0, 0, 0,      0, 0,          0, 0, 0,       1,   0, 3, 32'h11, 0, 0,        0, 1, 1);
        vecs[3]  = mk(1, 5, 32'h22, 1, 32'h1000,   0, 0, 0,       1,   0, 3, 32'h11, 0, 0,        0, 1, 1);
        vecs[4]  = mk(0, 0, 0,      0, 0,          1, 6, 32'h33,  1,   1, 5, 32'h22, 1, 32'h1000, 0, 1, 1);
        vecs[5]  = mk(0, 0, 0,      0, 0,          0, 0, 0,       1,   1, 6, 32'h33, 0, 0,        1, 1, 1);
        vecs[6]  = mk(0, 0, 0,      0, 0,          0, 0, 0,       1,   0, 6, 32'h33, 0, 0,        1, 1, 1);
        vecs[7]  = mk(1, 7, 32'h44, 0, 0,          0, 0, 0,       1,   0, 6, 32'h33, 0, 0,        1, 1, 1);
        vecs[8]  = mk(0, 0, 0,      0, 0,          1, 2, 32'h66,  1,   1, 7, 32'h44, 0, 0,        0, 1, 1);
        vecs[9]  = mk(1, 0, 32'h55, 0, 0,          0, 0, 0,       0,   1, 7, 32'h44, 0, 0,        0, 1, 1);
        vecs[10] = mk(1, 0, 32'h55, 0, 0,          0, 0, 0,       0,   1, 7, 32'h44, 0, 0,        0, 1, 1);
        vecs[11] = mk(1, 0, 32'h55, 0, 0,          0, 0, 0,       0,   1, 7, 32'h44, 0, 0,        0, 1, 1);
        vecs[12] = mk(0, 0, 0,      0, 0,          0, 0, 0,       1,   1, 2, 32'h66, 0, 0,        1, 1, 1);
        vecs[13] = mk(0, 0, 0,      0, 0,          0, 0, 0,       1,   0, 2, 32'h66, 0, 0,        1, 1, 1);

        // Reset
        idle_inputs();
        rst_in = 1'b1;
        #1;
        chk("ready low in reset", {30'b0, alu_ready, lsb_ready}, 32'd0);
        step();
        step();
        rst_in = 1'b0;
        #1;
        chk("reset cdb_valid", {31'b0, cdb_valid}, 32'd0);
        chk("reset cdb_rob_id", {29'b0, cdb_rob_id}, 32'd0);
        chk("reset cdb_value", cdb_value, 32'd0);
        chk("reset cdb_branch", {31'b0, cdb_br_taken} | cdb_br_target, 32'd0);
        chk("reset cdb_src", {31'b0, cdb_src}, 32'd0);
        chk("reset readies", {30'b0, alu_ready, lsb_ready}, 32'd3);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            alu_valid = vecs[i].av; alu_rob_id = vecs[i].aid; alu_value = vecs[i].aval;
            alu_br_taken = vecs[i].atk; alu_br_target = vecs[i].atg;
            lsb_valid = vecs[i].lv; lsb_rob_id = vecs[i].lid; lsb_value = vecs[i].lval;
            rdy_in = vecs[i].rdy; flush = 1'b0;
            step();
            checks++;
            if ({cdb_valid, cdb_rob_id, cdb_value, cdb_br_taken, cdb_br_target, cdb_src, alu_ready, lsb_ready} !==
                {vecs[i].ev, vecs[i].eid, vecs[i].e_val, vecs[i].etk, vecs[i].etg, vecs[i].esrc, vecs[i].ear, vecs[i].elr}) begin
                errors++;
                $display("FAIL vec%0d: got v=%0b id=%0d val=%0h tk=%0b tg=%0h src=%0b ar=%0b lr=%0b required v=%0b id=%0d val=%0h tk=%0b tg=%0h src=%0b ar=%0b lr=%0b",
                         i, cdb_valid, cdb_rob_id, cdb_value, cdb_br_taken, cdb_br_target, cdb_src, alu_ready, lsb_ready,
                         vecs[i].ev, vecs[i].eid, vecs[i].e_val, vecs[i].etk, vecs[i].etg, vecs[i].esrc, vecs[i].ear, vecs[i].elr);
            end
        end

        // Contention under the configured grant policy
        run_contention();

        // Flush with pushes in flight and in the flush cycle itself
        idle_inputs();
        alu_valid = 1'b1; alu_rob_id = 3'd1; alu_value = 32'hD1;
        lsb_valid = 1'b1; lsb_rob_id = 3'd1; lsb_value = 32'hE1;
        step();
        alu_rob_id = 3'd2; alu_value = 32'hD2;
        lsb_rob_id = 3'd2; lsb_value = 32'hE2;
        step();
        flush = 1'b1;
        alu_rob_id = 3'd3; alu_value = 32'hD3;
        lsb_rob_id = 3'd3; lsb_value = 32'hE3;
        step();
        chk("flush cdb_valid", {31'b0, cdb_valid}, 32'd0);
        chk("flush readies", {30'b0, alu_ready, lsb_ready}, 32'd3);
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post-flush quiet %0d", k), {31'b0, cdb_valid}, 32'd0);
        end
        alu_valid = 1'b1; alu_rob_id = 3'd4; alu_value = 32'h77;
        step();
        idle_inputs();
        step();
        chk("post-flush push valid", {31'b0, cdb_valid}, 32'd1);
        chk("post-flush push data", {cdb_rob_id, cdb_value[28:0]}, {3'd4, 29'h77});

        // Reset asserted with a result pending in the ALU FIFO
        alu_valid = 1'b1; alu_rob_id = 3'd1; alu_value = 32'h99;
        step();
        idle_inputs();
        rst_in = 1'b1;
        #1;
        chk("mid-reset alu_ready", {31'b0, alu_ready}, 32'd0);
        step();
        chk("mid-reset cdb", {31'b0, cdb_valid} | cdb_value, 32'd0);
        rst_in = 1'b0;
        step();
        chk("after reset pending lost", {31'b0, cdb_valid}, 32'd0);
        chk("after reset readies", {30'b0, alu_ready, lsb_ready}, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
